shiftaes_decryption: RTL and testbench

SHIFTAES_DECRYPTION -- requirements
Module: shiftaes_decryption

---
 rtl/shiftaes_pkg.sv | 43 ++++
 rtl/shiftaes_dec_round.sv | 26 ++
 rtl/shiftaes_decryption.sv | 119 +++++++++++
 tb/tb_shiftaes_decryption.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shiftaes_pkg.sv
// Shared definitions for the ShiftAES lane cipher (encryption and decryption sides).
// Lane widths, default round count, FSM state type and the bit-twiddling helpers.
package shiftaes_pkg;

    localparam int unsigned LANE_W         = 16;
    localparam int unsigned NUM_LANES      = 4;
    localparam int unsigned DEFAULT_ROUNDS = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic [4:0] popcount(input logic [15:0] x);
        logic [4:0] c;
        c = '0;
        for (int unsigned b = 0; b < 16; b++) begin
            c = c + {4'b0, x[b]};
        end
        return c;
    endfunction

    function automatic logic [15:0] rotl16(input logic [15:0] x, input logic [3:0] s);
        logic [31:0] t;
        t = {x, x} << s;
        return t[31:16];
    endfunction

    function automatic logic [15:0] rotr16(input logic [15:0] x, input logic [3:0] s);
        logic [31:0] t;
        t = {x, x} >> s;
        return t[15:0];
    endfunction

    // Rotation amount for a lane: popcount plus a lane-dependent offset, saturated at 15.
    function automatic logic [3:0] lane_shift(input logic [15:0] x, input logic [1:0] lane_mod3);
        logic [4:0] sum;
        sum = popcount(x) + {3'b0, lane_mod3} + 5'd1;
        return (sum > 5'd15) ? 4'd15 : sum[3:0];
    endfunction

endpackage

// File: rtl/shiftaes_dec_round.sv
// One combinational ShiftAES decryption round over all four 16-bit lanes.
// Even rounds rotate left, odd rounds rotate right, undoing the encryption rotation.
module shiftaes_dec_round
    import shiftaes_pkg::*;
(
    input  logic [LANE_W*NUM_LANES-1:0] state_i,
    input  logic [3:0]                  round_i,
    input  logic [127:0]                key_i,
    output logic [LANE_W*NUM_LANES-1:0] state_o
);

    logic [LANE_W-1:0] k;

    always_comb begin
        logic [LANE_W-1:0] z;
        logic [3:0]        s;
        k       = key_i[{round_i[2:0], 4'b0} +: LANE_W];
        state_o = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            z = state_i[i*LANE_W +: LANE_W] ^ k;
            s = lane_shift(z, 2'(i % 3));
            state_o[i*LANE_W +: LANE_W] = round_i[0] ? rotr16(z, s) : rotl16(z, s);
        end
    end

endmodule

// File: rtl/shiftaes_decryption.sv
// ShiftAES block decryptor: IDLE -> RUN (rounds ROUNDS-1 down to 0) -> DONE handshake FSM.
// Define SHIFTAES_DEC_FAST_EN to run two rounds per RUN cycle (latency ceil(ROUNDS/2)).
module shiftaes_decryption
    import shiftaes_pkg::*;
#(
    parameter int unsigned ROUNDS = DEFAULT_ROUNDS
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [63:0]  ciphertext,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  plaintext,
    output logic         busy
);

    state_e       state_q;
    logic [3:0]   r_q;
    logic [63:0]  data_q;
    logic [127:0] key_q;
    logic [63:0]  plaintext_q;
    logic         in_ready_q;
    logic         out_valid_q;
    logic         busy_q;

    logic [63:0]  round_a;
    logic [63:0]  step_d;
    logic [3:0]   r_d;
    logic         last_step;

    shiftaes_dec_round u_round_a (
        .state_i (data_q),
        .round_i (r_q),
        .key_i   (key_q),
        .state_o (round_a)
    );

`ifdef SHIFTAES_DEC_FAST_EN
    logic [63:0] round_b;

    // Second round consumes the first; its result is discarded when only round 0 remains.
    shiftaes_dec_round u_round_b (
        .state_i (round_a),
        .round_i (r_q - 4'd1),
        .key_i   (key_q),
        .state_o (round_b)
    );

    assign step_d    = (r_q == 4'd0) ? round_a : round_b;
    assign last_step = (r_q <= 4'd1);
    assign r_d       = r_q - 4'd2;
`else
    assign step_d    = round_a;
    assign last_step = (r_q == 4'd0);
    assign r_d       = r_q - 4'd1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            r_q         <= '0;
            data_q      <= '0;
            key_q       <= '0;
            plaintext_q <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        data_q     <= ciphertext;
                        key_q      <= key;
                        r_q        <= 4'(ROUNDS - 1);
                        state_q    <= RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                RUN: begin
                    data_q <= step_d;
                    if (last_step) begin
                        state_q     <= DONE;
                        plaintext_q <= step_d;
                        out_valid_q <= 1'b1;
                        r_q         <= '0;
                    end else begin
                        r_q <= r_d;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign plaintext = plaintext_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_shiftaes_decryption.sv
// Self-checking bench for shiftaes_decryption against a behavioural cipher model.
// Honours SHIFTAES_DEC_FAST_EN for the expected latency.
module tb_shiftaes_decryption;

    localparam int unsigned ROUNDS = 8;
`ifdef SHIFTAES_DEC_FAST_EN
    localparam int unsigned LAT = (ROUNDS + 1) / 2;
`else
    localparam int unsigned LAT = ROUNDS;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [63:0]  ciphertext = '0;
    logic [127:0] key = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [63:0]  plaintext;
    logic         busy;

    int unsigned errors = 0;
    int unsigned checks = 0;

    shiftaes_decryption #(.ROUNDS(ROUNDS)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ciphertext (ciphertext),
        .key        (key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .plaintext  (plaintext),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---- behavioural cipher model (plain integer arithmetic) ----
    function automatic int unsigned m_rot(input int unsigned x, input int unsigned s, input bit left);
        int unsigned v = x & 32'hFFFF;
        if (s == 0) return v;
        if (left) return ((v << s) | (v >> (16 - s))) & 32'hFFFF;
        return ((v >> s) | (v << (16 - s))) & 32'hFFFF;
    endfunction

    function automatic int unsigned m_amount(input int unsigned v, input int unsigned lane);
        int unsigned s = $countones(v[15:0]) + (lane % 3) + 1;
        return (s > 15) ? 15 : s;
    endfunction

    function automatic logic [63:0] m_enc(input logic [63:0] pt, input logic [127:0] k);
        logic [63:0] x = pt;
        for (int r = 0; r < int'(ROUNDS); r++) begin
            for (int i = 0; i < 4; i++) begin
                int unsigned v = 32'(x[16*i +: 16]);
                int unsigned kk = 32'(k[16*(r % 8) +: 16]);
                x[16*i +: 16] = 16'(m_rot(v, m_amount(v, i), (r % 2) == 1) ^ kk);
            end
        end
        return x;
    endfunction

    function automatic logic [63:0] m_dec(input logic [63:0] ct, input logic [127:0] k);
        logic [63:0] y = ct;
        for (int r = int'(ROUNDS) - 1; r >= 0; r--) begin
            for (int i = 0; i < 4; i++) begin
                int unsigned z = 32'(y[16*i +: 16] ^ k[16*(r % 8) +: 16]);
                y[16*i +: 16] = 16'(m_rot(z, m_amount(z, i), (r % 2) == 0));
            end
        end
        return y;
    endfunction

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Full transaction from a negedge: wait ready, accept, measure latency, check, release.
    task automatic do_txn(input string tag, input logic [63:0] ct, input logic [127:0] k,
                          input logic [63:0] exp, input bit check_lat);
        int unsigned n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, 64'(in_ready), 64'd1);
        in_valid   = 1'b1;
        ciphertext = ct;
        key        = k;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (check_lat) check({tag, "_lat"}, 64'(n), 64'(LAT));
        else if (!out_valid) check({tag, "_timeout"}, 64'(out_valid), 64'd1);
        check({tag, "_pt"}, plaintext, exp);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [63:0]  pt, ct, hold;
        logic [127:0] k;
        logic [63:0]  expq[$];
        int unsigned  last_acc, cyc, accepts, results;

        // Reset state
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_plaintext", plaintext, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Zero key / zero block, and the single-bit cancellation case
        do_txn("zero", 64'h0, 128'h0, 64'h0, 1'b1);
        do_txn("one", 64'h1, 128'h0, 64'h1, 1'b1);
        check("one_model", m_dec(64'h1, 128'h0), 64'h1);

        // Random ciphertext checked against the decryption model
        for (int t = 0; t < 20; t++) begin
            ct = {$urandom, $urandom};
            k  = rand_key();
            do_txn("rand_dec", ct, k, m_dec(ct, k), 1'b1);
        end

        // Backpressure: hold result for 5 cycles
        ct = {$urandom, $urandom};
        k  = rand_key();
        in_valid = 1'b1; ciphertext = ct; key = k;
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 0; c < int'(LAT) + 2 && !out_valid; c++) @(negedge clk);
        hold = m_dec(ct, k);
        for (int c = 0; c < 5; c++) begin
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_pt", plaintext, hold);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_busy", 64'(busy), 64'd1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_release_in_ready", 64'(in_ready), 64'd1);
        check("bp_release_out_valid", 64'(out_valid), 64'd0);

        // Reset during RUN (around round 3)
        in_valid = 1'b1; ciphertext = {$urandom, $urandom}; key = rand_key();
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_in_ready", 64'(in_ready), 64'd0);
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_pt", plaintext, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_ready_after", 64'(in_ready), 64'd1);
        ct = {$urandom, $urandom};
        k  = rand_key();
        do_txn("after_rst", ct, k, m_dec(ct, k), 1'b1);

        // Round trip of 1000 random pairs through the encryption model
        for (int t = 0; t < 1000; t++) begin
            pt = {$urandom, $urandom};
            k  = rand_key();
            do_txn("roundtrip", m_enc(pt, k), k, pt, 1'b0);
        end

        // Back-to-back with in_valid and out_ready held high
        accepts = 0; results = 0; cyc = 0; last_acc = 0;
        ciphertext = {$urandom, $urandom};
        key = rand_key();
        in_valid = 1'b1;
        out_ready = 1'b1;
        while (cyc < 8 * (LAT + 2) + 4) begin
            if (out_valid) begin
                results++;
                if (expq.size() == 0) check("b2b_extra_result", 64'd1, 64'd0);
                else check("b2b_pt", plaintext, expq.pop_front());
            end
            if (in_ready && in_valid) begin
                if (accepts > 0) check("b2b_period", 64'(cyc - last_acc), 64'(LAT + 2));
                expq.push_back(m_dec(ciphertext, key));
                last_acc = cyc;
                accepts++;
                @(negedge clk);
                cyc++;
                ciphertext = {$urandom, $urandom};
                key = rand_key();
                if (cyc >= 8 * (LAT + 2)) in_valid = 1'b0;
                continue;
            end
            if (cyc >= 8 * (LAT + 2)) in_valid = 1'b0;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        for (int c = 0; c < int'(LAT) + 4; c++) begin
            if (out_valid) begin
                results++;
                if (expq.size() == 0) check("b2b_extra_result", 64'd1, 64'd0);
                else check("b2b_pt", plaintext, expq.pop_front());
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
        check("b2b_accepts", 64'(accepts >= 7), 64'd1);
        check("b2b_results", 64'(results), 64'(accepts));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
